// File: rtl/core_mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
//   mdu_state_t : FSM state encoding (IDLE, MUL, DIV, FIX, DONE)
//   mdu_op_t    : 3-bit op encoding; bit 2 = divide class, bit 1 (divide) = remainder
//   abs_n       : magnitude of a 32- or 64-bit operand, zero-extended to 64 bits
//   sext_word   : sign-extend bit 31 across the upper 32 bits
package core_mdu_pkg;

  localparam int unsigned MDU_XLEN = 64;

  typedef enum logic [2:0] {
    MDU_IDLE = 3'd0,
    MDU_MUL  = 3'd1,
    MDU_DIV  = 3'd2,
    MDU_FIX  = 3'd3,
    MDU_DONE = 3'd4
  } mdu_state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHU  = 3'd2,
    OP_MULHSU = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  // Signed operands are replaced by their magnitude; unsigned (or word) operands
  // are simply truncated to N bits. -(-2^(N-1)) wraps to 2^(N-1), which is the
  // correct unsigned magnitude.
  function automatic logic [63:0] abs_n(input logic [63:0] x, input logic word,
                                        input logic sgn);
    logic [31:0] lo;
    logic [63:0] r;
    if (word) begin
      lo = (sgn && x[31]) ? -x[31:0] : x[31:0];
      r  = {32'b0, lo};
    end else begin
      r  = (sgn && x[63]) ? -x : x;
    end
    return r;
  endfunction

  function automatic logic [63:0] sext_word(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/core_mdu_divstep.sv
// One restoring-division step.
//   rem_i/quot_i  : partial remainder and dividend/quotient shift register
//   divisor_i     : unsigned divisor magnitude
//   rem_o/quot_o  : updated remainder; quotient with the new bit shifted into the LSB
module core_mdu_divstep
  import core_mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ge;

  // shifted < 2*divisor always holds, so a non-negative diff fits in XLEN bits.
  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    ge      = ~diff[XLEN];
    rem_o   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_o  = {quot_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/core_pipe_exec_mdu_iter.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Ports:
//   g_clk, g_resetn          clock, synchronous active-low reset
//   flush                    abort any in-flight op and return to IDLE (rd held)
//   valid                    operands/op valid, held until accepted
//   pipe_advance             execute stage consumes rd this cycle
//   op_word                  32-bit word op; result sign-extended to XLEN
//   op_mul .. op_remu        one-hot op select
//   rs1, rs2                 source operands
//   ready                    rd holds a valid result
//   rd                       registered result
// Operands are converted to magnitudes at accept, iterated unsigned, and the
// sign is reapplied in the single FIX cycle.
module core_pipe_exec_mdu_iter
  import core_mdu_pkg::*;
#(
  parameter int unsigned XLEN       = MDU_XLEN,
  parameter int unsigned MUL_UNROLL = 1,
  parameter int unsigned DIV_UNROLL = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            valid,
  input  logic            pipe_advance,
  input  logic            op_word,
  input  logic            op_mul,
  input  logic            op_mulh,
  input  logic            op_mulhu,
  input  logic            op_mulhsu,
  input  logic            op_div,
  input  logic            op_divu,
  input  logic            op_rem,
  input  logic            op_remu,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic [XLEN-1:0] rd
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [CW-1:0] MUL_CNT_X = CW'(XLEN / MUL_UNROLL);
  localparam logic [CW-1:0] MUL_CNT_W = CW'(32 / MUL_UNROLL);
  localparam logic [CW-1:0] DIV_CNT_X = CW'(XLEN / DIV_UNROLL);
  localparam logic [CW-1:0] DIV_CNT_W = CW'(32 / DIV_UNROLL);

  mdu_state_t      state_q, state_d;
  mdu_op_t         op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN-1:0] rd_q, rd_d;

  // ---------------------------------------------------------------- decode
  mdu_op_t         op_sel;
  logic            any_op;
  logic            s1, s2, rs1_sgn, rs2_sgn, neg_new;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a1, a2, special_rd;

  always_comb begin
    op_sel = OP_MUL;
    if (op_mul)         op_sel = OP_MUL;
    else if (op_mulh)   op_sel = OP_MULH;
    else if (op_mulhu)  op_sel = OP_MULHU;
    else if (op_mulhsu) op_sel = OP_MULHSU;
    else if (op_div)    op_sel = OP_DIV;
    else if (op_divu)   op_sel = OP_DIVU;
    else if (op_rem)    op_sel = OP_REM;
    else if (op_remu)   op_sel = OP_REMU;
    any_op = op_mul | op_mulh | op_mulhu | op_mulhsu |
             op_div | op_divu | op_rem | op_remu;

    s1 = op_word ? rs1[31] : rs1[XLEN-1];
    s2 = op_word ? rs2[31] : rs2[XLEN-1];
    rs1_sgn = (op_sel == OP_MULH) || (op_sel == OP_MULHSU) ||
              (op_sel == OP_DIV)  || (op_sel == OP_REM);
    rs2_sgn = (op_sel == OP_MULH) || (op_sel == OP_DIV) || (op_sel == OP_REM);
    a1 = abs_n(rs1, op_word, rs1_sgn);
    a2 = abs_n(rs2, op_word, rs2_sgn);

    case (op_sel)
      OP_MULH, OP_DIV:   neg_new = s1 ^ s2;
      OP_MULHSU, OP_REM: neg_new = s1;
      default:           neg_new = 1'b0;
    endcase

    div_zero = op_word ? (rs2[31:0] == 32'd0) : (rs2 == '0);
    div_ovf  = ((op_sel == OP_DIV) || (op_sel == OP_REM)) &&
               (op_word ? ((rs1[31:0] == 32'h8000_0000) && (rs2[31:0] == 32'hFFFF_FFFF))
                        : ((rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)));

    // Early-out results: divide-by-zero first, then signed overflow.
    if (div_zero)
      special_rd = op_sel[1] ? (op_word ? sext_word(rs1) : rs1) : '1;
    else
      special_rd = op_sel[1] ? '0 : (op_word ? sext_word(rs1) : rs1);
  end

  // ---------------------------------------------------------------- iterate
  logic [PW-1:0]   acc_n, mc_n;
  logic [XLEN-1:0] mp_n;

  always_comb begin
    acc_n = acc_q;
    mc_n  = mcand_q;
    mp_n  = mplier_q;
    for (int i = 0; i < MUL_UNROLL; i++) begin
      if (mp_n[0]) acc_n = acc_n + mc_n;
      mc_n = mc_n << 1;
      mp_n = mp_n >> 1;
    end
  end

  logic [XLEN-1:0] rem_c  [DIV_UNROLL+1];
  logic [XLEN-1:0] quot_c [DIV_UNROLL+1];

  assign rem_c[0]  = rem_q;
  assign quot_c[0] = quot_q;

  for (genvar g = 0; g < DIV_UNROLL; g++) begin : g_divstep
    core_mdu_divstep #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_c[g]),
      .quot_i    (quot_c[g]),
      .divisor_i (divisor_q),
      .rem_o     (rem_c[g+1]),
      .quot_o    (quot_c[g+1])
    );
  end

  // ---------------------------------------------------------------- fix-up
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] dsel, dres, fix_res;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    dsel = op_q[1] ? rem_q : quot_q;
    dres = neg_q ? -dsel : dsel;
    case (op_q)
      OP_MUL:
        fix_res = word_q ? sext_word(prod[XLEN-1:0]) : prod[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU:
        fix_res = word_q ? sext_word({32'b0, prod[63:32]}) : prod[PW-1:XLEN];
      default:
        fix_res = word_q ? sext_word(dres) : dres;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    rd_d      = rd_q;

    case (state_q)
      MDU_IDLE: begin
        if (valid && any_op) begin
          op_d   = op_sel;
          word_d = op_word;
          neg_d  = neg_new;
          if (op_sel[2] && (div_zero || div_ovf)) begin
            rd_d    = special_rd;
            state_d = MDU_DONE;
          end else if (op_sel[2]) begin
            rem_d     = '0;
            // Word dividends sit in the top half so the step always shifts out bit XLEN-1.
            quot_d    = op_word ? {a1[31:0], 32'b0} : a1;
            divisor_d = a2;
            cnt_d     = op_word ? DIV_CNT_W : DIV_CNT_X;
            state_d   = MDU_DIV;
          end else begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, a1};
            mplier_d = a2;
            cnt_d    = op_word ? MUL_CNT_W : MUL_CNT_X;
            state_d  = MDU_MUL;
          end
        end
      end
      MDU_MUL: begin
        acc_d    = acc_n;
        mcand_d  = mc_n;
        mplier_d = mp_n;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = MDU_FIX;
      end
      MDU_DIV: begin
        rem_d  = rem_c[DIV_UNROLL];
        quot_d = quot_c[DIV_UNROLL];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_d == '0) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        rd_d    = fix_res;
        state_d = MDU_DONE;
      end
      MDU_DONE: begin
        if (pipe_advance) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase

    // flush wins over everything, including a same-cycle accept; rd keeps its value.
    if (flush) begin
      state_d = MDU_IDLE;
      cnt_d   = '0;
      rd_d    = rd_q;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q   <= MDU_IDLE;
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      rd_q      <= rd_d;
    end
  end

  assign ready = (state_q == MDU_DONE);
  assign rd    = rd_q;

endmodule

// File: tb/tb_core_pipe_exec_mdu_iter.sv
// Self-checking bench for core_pipe_exec_mdu_iter: directed corner cases plus
// randomized ops compared against an arithmetic reference model.
module tb_core_pipe_exec_mdu_iter;

  localparam int unsigned XLEN = 64;
  localparam int unsigned MU   = 4;
  localparam int unsigned DU   = 2;

  logic            g_clk = 1'b0;
  logic            g_resetn = 1'b0;
  logic            flush = 1'b0;
  logic            valid = 1'b0;
  logic            pipe_advance = 1'b0;
  logic            op_word = 1'b0;
  logic [7:0]      op_oh = 8'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            ready;
  logic [XLEN-1:0] rd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 g_clk = ~g_clk;

  core_pipe_exec_mdu_iter #(.XLEN(XLEN), .MUL_UNROLL(MU), .DIV_UNROLL(DU)) dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .flush        (flush),
    .valid        (valid),
    .pipe_advance (pipe_advance),
    .op_word      (op_word),
    .op_mul       (op_oh[0]),
    .op_mulh      (op_oh[1]),
    .op_mulhu     (op_oh[2]),
    .op_mulhsu    (op_oh[3]),
    .op_div       (op_oh[4]),
    .op_divu      (op_oh[5]),
    .op_rem       (op_oh[6]),
    .op_remu      (op_oh[7]),
    .rs1          (rs1),
    .rs2          (rs2),
    .ready        (ready),
    .rd           (rd)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  // Ops: 0 mul 1 mulh 2 mulhu 3 mulhsu 4 div 5 divu 6 rem 7 remu
  function automatic logic [63:0] ref_mdu(input int op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
    int                 n;
    logic [63:0]        mask, an, bn, r;
    logic [127:0]       ea_s, eb_s, ea_u, eb_u, p, ph;
    logic signed [63:0] va, vb, vmin;
    n    = word ? 32 : 64;
    mask = word ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    an   = a & mask;
    bn   = b & mask;
    ea_u = {64'd0, an};
    eb_u = {64'd0, bn};
    ea_s = (word ? a[31] : a[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, an | ~mask} : ea_u;
    eb_s = (word ? b[31] : b[63]) ? {64'hFFFF_FFFF_FFFF_FFFF, bn | ~mask} : eb_u;
    va   = ea_s[63:0];
    vb   = eb_s[63:0];
    vmin = word ? -64'sd2147483648 : {1'b1, 63'd0};
    r    = 64'd0;
    case (op)
      0: begin p = ea_u * eb_u; r = p[63:0]; end
      1: begin p = ea_s * eb_s; ph = p >> n; r = ph[63:0]; end
      2: begin p = ea_u * eb_u; ph = p >> n; r = ph[63:0]; end
      3: begin p = ea_s * eb_u; ph = p >> n; r = ph[63:0]; end
      default: begin
        if (bn == 64'd0)                                      r = (op >= 6) ? an : mask;
        else if ((op == 4 || op == 6) && va == vmin && vb == -64'sd1) r = (op == 6) ? 64'd0 : an;
        else if (op == 4) r = va / vb;
        else if (op == 5) r = an / bn;
        else if (op == 6) r = va % vb;
        else              r = an % bn;
      end
    endcase
    r = r & mask;
    return word ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic int ref_lat(input int op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
    int          n;
    logic [63:0] mask;
    logic        zero, ovf;
    n    = word ? 32 : 64;
    mask = word ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    zero = (b & mask) == 64'd0;
    ovf  = (op == 4 || op == 6) && ((a & mask) == (word ? 64'h8000_0000 : 64'h8000_0000_0000_0000))
           && ((b & mask) == mask);
    if (op < 4) return n / MU + 2;
    if (zero || ovf) return 1;
    return n / DU + 2;
  endfunction

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag, input int op, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int          cyc;
    logic [63:0] op_bits;
    op_bits = 64'd1 << op;
    op_oh   = op_bits[7:0];
    op_word = word;
    rs1     = a;
    rs2     = b;
    valid   = 1'b1;
    cyc = 0;
    do begin
      @(posedge g_clk); #1;
      cyc++;
    end while (!ready && cyc < 300);
    chk({tag, ".lat"}, 64'(cyc), 64'(ref_lat(op, word, a, b)));
    chk({tag, ".rd"}, rd, exp);
    // valid still high in DONE must not start anything; result must hold.
    @(posedge g_clk); #1;
    chk({tag, ".hold"}, {ready, rd[62:0]}, {1'b1, exp[62:0]});
    valid        = 1'b0;
    pipe_advance = 1'b1;
    @(posedge g_clk); #1;
    pipe_advance = 1'b0;
    chk({tag, ".consumed"}, 64'(ready), 64'd0);
  endtask

  function automatic logic [63:0] pick_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h0000_0000_8000_0000;
      4:       v = 64'($urandom_range(0, 20));
      5:       v = -64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] last_rd;
    repeat (3) @(posedge g_clk);
    #1;
    chk("reset.ready", 64'(ready), 64'd0);
    chk("reset.rd", rd, 64'd0);
    g_resetn = 1'b1;
    @(posedge g_clk); #1;

    // Directed corner cases.
    run_op("mulhsu_m1_2", 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divw_ovf", 4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000);
    run_op("remw_ovf", 6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run_op("divu_zero", 5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_zero", 7, 1'b0, 64'h1234, 64'd0, 64'h1234);
    run_op("rem_m7_2", 6, 1'b0, -64'd7, 64'd2, -64'd1);
    run_op("div_m7_2", 4, 1'b0, -64'd7, 64'd2, -64'd3);
    run_op("mulw_7fff", 0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("div_ovf64", 4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000);
    run_op("mulhu_max", 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE);

    // Flush in cycle 5 of a multiply.
    last_rd = rd;
    op_oh = 8'b0000_0001; op_word = 1'b0; rs1 = 64'd123; rs2 = 64'd456; valid = 1'b1;
    repeat (4) @(posedge g_clk);
    #1;
    valid = 1'b0;
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    chk("flush.ready", 64'(ready), 64'd0);
    chk("flush.rd_held", rd, last_rd);
    repeat (20) @(posedge g_clk);
    #1;
    chk("flush.no_result", 64'(ready), 64'd0);
    run_op("mul_3_5", 0, 1'b0, 64'd3, 64'd5, 64'd15);

    // Flush in the same cycle as a start that would finish in one cycle.
    last_rd = rd;
    op_oh = 8'b0010_0000; op_word = 1'b0; rs1 = 64'h55; rs2 = 64'd0; valid = 1'b1;
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    valid = 1'b0;
    @(posedge g_clk); #1;
    chk("flush_start.ready", 64'(ready), 64'd0);
    chk("flush_start.rd", rd, last_rd);

    // Reset in the middle of a divide clears rd too.
    op_oh = 8'b0001_0000; op_word = 1'b0; rs1 = 64'd1000; rs2 = 64'd7; valid = 1'b1;
    repeat (3) @(posedge g_clk);
    #1;
    valid = 1'b0;
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    chk("midreset.ready", 64'(ready), 64'd0);
    chk("midreset.rd", rd, 64'd0);
    @(posedge g_clk); #1;

    // Randomized ops against the reference model.
    for (int k = 0; k < 80; k++) begin
      int          op;
      logic        w;
      logic [63:0] a, b;
      op = int'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = pick_operand();
      b  = pick_operand();
      run_op($sformatf("rnd%0d_op%0d_w%0d", k, op, w), op, w, a, b, ref_mdu(op, w, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
